// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 receive front-end: prefix byte values,
// receiver FSM state encoding and the layout of one decoded FIFO entry.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // One decoded key code plus the prefixes that preceded it.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  localparam int PS2_ENTRY_W = $bits(ps2_entry_t);

endpackage

// File: rtl/ps2_code_fifo.sv
// ps2_code_fifo
// Show-ahead FIFO for decoded PS/2 entries.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : offer an entry for storage
//   pop       : remove the head entry (ignored when empty)
//   dout      : head entry, all zeros when empty
//   count     : occupancy
//   empty     : no entries stored
//   pushed    : the offered entry was stored this cycle
//   dropped   : the offered entry was discarded because the FIFO is full
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [PS2_ENTRY_W-1:0]       din,
  input  logic                         pop,
  output logic [PS2_ENTRY_W-1:0]       dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         pushed,
  output logic                         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PS2_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_q;
  logic                   full;
  logic                   do_push;
  logic                   do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop on an empty FIFO is ignored even if a push arrives in the same
  // cycle; a push into a full FIFO is only kept when a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign pushed  = do_push;
  assign dropped = push & full & ~do_pop;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/ps2_rx_frontend.sv
// ps2_rx_frontend
// PS/2 keyboard receive front-end: synchronises and glitch-filters the PS/2
// lines, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop),
// folds E0/F0 prefixes into flags and buffers decoded codes in a FIFO.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   ps2_clk, ps2_data : raw PS/2 lines
//   rd_en             : pop head entry
//   code_out, ext_out, brk_out : head entry (zeros when empty)
//   valid, fifo_count : FIFO not empty / occupancy
//   byte_strobe       : pulse per entry stored
//   err_parity        : pulse on parity failure
//   err_frame         : pulse on bad stop bit or inter-bit timeout
//   overflow          : pulse when an entry is dropped because the FIFO is full
// Handshake: the head entry is presented whenever valid=1; it is consumed on
// a cycle where rd_en=1 and valid=1. rd_en while valid=0 has no effect.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  input  logic                              rd_en,
  output logic [7:0]                        code_out,
  output logic                              ext_out,
  output logic                              brk_out,
  output logic                              valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              byte_strobe,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              overflow
);

  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  // ---------------- synchronisers and clock filter ----------------
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt;
  logic          clk_filt_d;
  logic          fall;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_filt_d <= clk_filt;
      // Count consecutive samples that disagree with the filtered value;
      // any agreeing sample restarts the count.
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN-1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  // ---------------- receiver FSM ----------------
  ps2_state_t    state_q;
  ps2_state_t    state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tout_cnt;
  logic          tout_hit;
  logic          byte_ok;
  logic          perr_det;
  logic          ferr_det;

  assign tout_hit = (state_q != ST_IDLE) && (tout_cnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tout_hit) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   if (!data_s) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Frame verdict on the stop-bit fall. A bad stop bit dominates parity.
  always_comb begin
    byte_ok  = 1'b0;
    perr_det = 1'b0;
    ferr_det = 1'b0;
    if (tout_hit) begin
      ferr_det = 1'b1;
    end else if (fall && state_q == ST_STOP) begin
      if (!data_s)                  ferr_det = 1'b1;
      else if (^{shift_q, parity_q}) byte_ok  = 1'b1;
      else                          perr_det = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tout_cnt <= '0;
    end else begin
      if (state_q == ST_IDLE || fall) tout_cnt <= '0;
      else                            tout_cnt <= tout_cnt + 1'b1;
      if (fall) begin
        case (state_q)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift_q <= {data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          ST_PARITY: parity_q <= data_s;
          default:   ;
        endcase
      end
    end
  end

  // ---------------- prefix folding ----------------
  logic       acc_q;
  logic [7:0] acc_code;
  logic       ext_pend;
  logic       brk_pend;
  logic       is_ext;
  logic       is_brk;
  logic       push;
  ps2_entry_t push_entry;
  ps2_entry_t head;
  logic       fifo_empty;

  // The accepted byte is registered so the push lands in the cycle after
  // the stop-bit fall; errors are reported as registered pulses alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= 1'b0;
      acc_code   <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      acc_q      <= byte_ok;
      err_parity <= perr_det;
      err_frame  <= ferr_det;
      if (byte_ok) acc_code <= shift_q;
    end
  end

  assign is_ext = (acc_code == PS2_EXT_PREFIX);
  assign is_brk = (acc_code == PS2_BRK_PREFIX);
  assign push   = acc_q & ~is_ext & ~is_brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (perr_det || ferr_det) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (acc_q) begin
      if (is_ext) begin
        ext_pend <= 1'b1;
      end else if (is_brk) begin
        brk_pend <= 1'b1;
      end else begin
        // Flags are consumed whether the entry is stored or dropped.
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.ext  = ext_pend;
    push_entry.brk  = brk_pend;
    push_entry.code = acc_code;
  end

  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (push_entry),
    .pop     (rd_en),
    .dout    (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .pushed  (byte_strobe),
    .dropped (overflow)
  );

  assign valid    = ~fifo_empty;
  assign code_out = head.code;
  assign ext_out  = head.ext;
  assign brk_out  = head.brk;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// tb_ps2_rx_frontend
// Drives PS/2 frames into ps2_rx_frontend and compares every visible effect
// against a frame-level model: a queue of expected FIFO entries, pending
// prefix flags and expected pulse counts.
module tb_ps2_rx_frontend;
  import ps2_pkg::*;

  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int FIFO_DEPTH  = 4;
  localparam int CW          = $clog2(FIFO_DEPTH+1);
  localparam int HALF        = 200;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          ps2_clk;
  logic          ps2_data;
  logic          rd_en;
  logic [7:0]    code_out;
  logic          ext_out;
  logic          brk_out;
  logic          valid;
  logic [CW-1:0] fifo_count;
  logic          byte_strobe;
  logic          err_parity;
  logic          err_frame;
  logic          overflow;

  always #5 clk = ~clk;

  ps2_rx_frontend #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .code_out    (code_out),
    .ext_out     (ext_out),
    .brk_out     (brk_out),
    .valid       (valid),
    .fifo_count  (fifo_count),
    .byte_strobe (byte_strobe),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .overflow    (overflow)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_strobe = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  int exp_strobe = 0, exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int strobe_cyc = 0;
  int stop_cyc   = 0;
  int push_lat   = 8;

  logic [9:0] exp_q[$];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (byte_strobe) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
    if (err_parity) n_perr++;
    if (err_frame)  n_ferr++;
    if (overflow)   n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bit,
                             input bit pop_at_push);
    if (!stop_bit) begin
      exp_ferr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (par_bad) begin
      exp_perr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (pop_at_push && exp_q.size() > 0) void'(exp_q.pop_front());
      if (exp_q.size() < FIFO_DEPTH) begin
        exp_q.push_back({m_ext, m_brk, b});
        exp_strobe++;
      end else begin
        exp_ovf++;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // ---------------- drivers ----------------
  // Bits change while ps2_clk is high; each bit is one high and one low phase.
  task automatic send_bits(input logic [10:0] f, input int n, input int half,
                           input bit pop_at_stop);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1 ps2_data = f[k];
      repeat (half) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (k == 10) stop_cyc = cyc;
      for (int i = 1; i <= half; i++) begin
        @(posedge clk); #1;
        if (pop_at_stop && k == 10) rd_en = (i == push_lat);
      end
      rd_en   = 1'b0;
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bit,
                            input int half, input bit pop_at_stop);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ par_bad, b, 1'b0};
    send_bits(f, 11, half, pop_at_stop);
    @(posedge clk); #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    model_frame(b, par_bad, stop_bit, pop_at_stop);
  endtask

  task automatic check_state(input string tag);
    logic [9:0] exp_head;
    @(negedge clk);
    exp_head = (exp_q.size() > 0) ? exp_q[0] : 10'd0;
    check({tag, ":strobe"},   n_strobe, exp_strobe);
    check({tag, ":parity"},   n_perr,   exp_perr);
    check({tag, ":frame"},    n_ferr,   exp_ferr);
    check({tag, ":overflow"}, n_ovf,    exp_ovf);
    check({tag, ":count"},    32'(fifo_count), exp_q.size());
    check({tag, ":valid"},    32'(valid), 32'(exp_q.size() > 0));
    check({tag, ":head"},     32'({ext_out, brk_out, code_out}), 32'(exp_head));
  endtask

  task automatic pop_one(input string tag);
    logic [9:0] exp_head;
    @(negedge clk);
    exp_head = (exp_q.size() > 0) ? exp_q[0] : 10'd0;
    check({tag, ":pop_head"}, 32'({ext_out, brk_out, code_out}), 32'(exp_head));
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rb;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({code_out, ext_out, brk_out, valid, fifo_count, byte_strobe,
               err_parity, err_frame, overflow}), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Single good frame, then pop.
    send_frame(8'h1C, 0, 1, HALF, 0);
    push_lat = strobe_cyc - stop_cyc;
    if (push_lat < 1 || push_lat > 50) push_lat = 8;
    check_state("t1");
    pop_one("t1");
    check_state("t1_empty");

    // Extended break code.
    send_frame(8'hE0, 0, 1, HALF, 0);
    send_frame(8'hF0, 0, 1, HALF, 0);
    check_state("t2_prefix");
    send_frame(8'h75, 0, 1, HALF, 0);
    check_state("t2");
    pop_one("t2");

    // Parity error, and an error discarding a pending E0.
    send_frame(8'h1C, 1, 1, HALF, 0);
    check_state("t3_bad");
    send_frame(8'hE0, 0, 1, HALF, 0);
    send_frame(8'h1C, 1, 1, HALF, 0);
    send_frame(8'h1C, 0, 1, HALF, 0);
    check_state("t3");
    pop_one("t3");

    // Bad stop bit, then inter-bit timeout, then recovery.
    send_frame(8'h1C, 0, 0, HALF, 0);
    check_state("t4_stop");
    send_bits({2'b11, 8'h2A, 1'b0}, 4, HALF, 0);
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (TIMEOUT_CYC + 200) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    exp_ferr++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    check("t4_idle", 32'(dut.state_q), 32'd0);
    check_state("t4_timeout");
    send_frame(8'h2A, 0, 1, HALF, 0);
    check_state("t4_recover");
    pop_one("t4");

    // Overflow, then push with simultaneous pop while full.
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 0, 1, HALF / 2, 0);
    check_state("t5_full");
    send_frame(8'h07, 0, 1, HALF / 2, 1);
    check_state("t5_pushpop");

    // Reset mid-frame, clock glitch, then a clean frame.
    send_bits({2'b11, 8'h5A, 1'b0}, 4, HALF, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1 check("t6_rst_outputs",
             32'({code_out, ext_out, brk_out, valid, fifo_count, byte_strobe,
                  err_parity, err_frame, overflow}), 32'd0);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 ps2_data = 1'b0; ps2_clk = 1'b0;
    @(posedge clk); #1 ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (50) @(posedge clk);
    check_state("t6_glitch");
    send_frame(8'h5A, 0, 1, HALF, 0);
    check_state("t6");
    pop_one("t6");

    // Randomised frames with short bit period and random pops.
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 5))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      send_frame(rb, $urandom_range(0, 6) == 0, $urandom_range(0, 7) != 0, 30, 0);
      check_state("rand");
      for (int p = 0; p < $urandom_range(0, 2); p++) pop_one("rand");
    end
    while (exp_q.size() > 0) pop_one("drain");
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
Parametrised PS/2 keyboard receive front-end that replaces the ad-hoc receiver-ready edge/flag strobe logic. It synchronises and glitch-filters the PS/2 clock and data lines, deframes 11-bit frames, and checks parity, stop bit and inter-bit timeout. It folds E0 (extended) and F0 (break) prefixes into flags and buffers decoded codes in a FIFO for the downstream key FSM and VGA path.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered PS/2 clock changes (>=2)
TIMEOUT_CYC, 50000, clk cycles allowed between falling edges inside a frame before abort
FIFO_DEPTH, 4, entries in the code FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock line
ps2_data  in  1  raw PS/2 data line
rd_en  in  1  pop head entry (ignored when empty)
code_out  out  8  head scan code (show-ahead); 0 when empty
ext_out  out  1  head entry was preceded by E0
brk_out  out  1  head entry was preceded by F0
valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupancy
byte_strobe  out  1  one-cycle pulse per entry pushed
err_parity  out  1  one-cycle pulse on parity failure
err_frame  out  1  one-cycle pulse on bad stop bit or timeout
overflow  out  1  one-cycle pulse when an entry is dropped because the FIFO is full

Behaviour:
- Reset (async): all outputs 0. Synchronisers and filtered clock reset to 1. FSM in IDLE. FIFO empty. Pending flags cleared. Timeout counter 0. A reset mid-frame discards the partial frame.
- Two-FF synchronisers on both lines. Filtered clock toggles only after FILTER_LEN consecutive synchronised samples differ from its current value.
- fall = one-cycle pulse on a 1->0 transition of the filtered clock. Data is sampled from the synchronised data line on fall.
- FSM states and transitions:
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: shift LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on fall, return to IDLE and check the frame:
    - stop=1 and odd parity over data+parity: byte accepted.
    - stop=0: err_frame pulse.
    - stop=1 but parity wrong: err_parity pulse.
    - stop=0 and parity wrong: err_frame only.
- Timeout: counter increments while not IDLE and clears on every fall. When it reaches TIMEOUT_CYC: err_frame pulse, go to IDLE, clear pending flags.
- Any error clears the pending flags.
- Prefix handling of accepted bytes:
  - E0 sets ext_pend; F0 sets brk_pend. Neither is pushed.
  - Any other byte is pushed as {ext_pend, brk_pend, code}, then both pending flags clear.
  - F0 after E0 keeps both flags set.
- Push timing: push occurs in the cycle after the stop-bit fall. byte_strobe is high in the push cycle. valid and fifo_count update on the next edge.
- FIFO:
  - Show-ahead: the head entry is visible on code_out/ext_out/brk_out whenever valid=1.
  - Pop on rd_en & valid.
  - Push when not full, or when full with a simultaneous pop (count unchanged).
  - Push while full with no pop: entry dropped, overflow pulse, no byte_strobe, pending flags still cleared.
  - Push and pop in the same cycle while empty: the push is kept and the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- Error and overflow pulses are independent and may coincide with a pop.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0
  - FSM state enum IDLE/DATA/PARITY/STOP
  - FIFO entry typedef {ext, brk, code[7:0]}
- One natural sub-module: ps2_code_fifo, a parametrised show-ahead FIFO with count and push/pop/full handling. Synchronisers, filter, FSM and prefix logic stay in the top.

Test Plan:
(All scenarios use FILTER_LEN=4, TIMEOUT_CYC=1000, FIFO_DEPTH=4, PS/2 bit period 400 clk.)
1. Valid frame 8'h1C (parity 0) -> one byte_strobe; code_out=8'h1C, ext_out=0, brk_out=0, valid=1, fifo_count=1; rd_en pulse -> valid=0, code_out=0.
2. Sequence E0, F0, 75 -> single entry code_out=8'h75, ext_out=1, brk_out=1; prefixes produce no byte_strobe.
3. Frame 8'h1C with parity bit 1 -> err_parity pulse, no push. Next frame 8'h1C with E0 before the bad frame -> entry has ext_out=0.
4. Stop bit 0 -> err_frame. Separately, ps2_clk held low for 1000+ cycles after 3 data bits -> err_frame, FSM IDLE; next good frame 8'h2A is received correctly.
5. Six frames 01..06 with no rd_en -> FIFO holds 01..04, overflow pulses twice, fifo_count=4. Push with simultaneous rd_en when full -> count stays 4, head advances to 02.
6. rst asserted mid-DATA and a 1-cycle glitch on ps2_clk -> all outputs 0 immediately; glitch produces no fall; following frame 8'h5A is received intact.
